// File: rtl/peg_l2_mdio_pkg.sv
// Shared MDIO constants, FSM state type and clause-22 read header builder for the
// RMII link controller and its MDC generator.
package peg_l2_mdio_pkg;

  localparam logic [1:0] MDIO_ST           = 2'b01;
  localparam logic [1:0] MDIO_OP_RD        = 2'b10;
  localparam int         MDIO_PREAMBLE_LEN = 32;
  localparam int         MDIO_HDR_LEN      = 14;
  localparam int         MDIO_DATA_LEN     = 16;
  localparam logic [4:0] BMSR_ADDR         = 5'd1;
  localparam int         BMSR_LINK_BIT     = 2;

  typedef enum logic [2:0] {
    IDLE_S      = 3'd0,
    PREAMBLE_S  = 3'd1,
    HDR_S       = 3'd2,
    TA_S        = 3'd3,
    DATA_S      = 3'd4,
    DONE_S      = 3'd5,
    WAIT_POLL_S = 3'd6
  } mdio_state_e;

  typedef enum logic {
    SEL_BMSR  = 1'b0,
    SEL_SPEED = 1'b1
  } mdio_reg_sel_e;

  // ST, OP, PHYAD, REGAD packed MSB-first as they leave on the wire.
  function automatic logic [13:0] mdio_rd_hdr(input logic [4:0] phy_addr,
                                              input logic [4:0] reg_addr);
    return {MDIO_ST, MDIO_OP_RD, phy_addr, reg_addr};
  endfunction

endpackage

// File: rtl/peg_l2_mdio_clk_gen.sv
// MDC generator: free-runs while run=1, toggling every MDC_DIV cycles, and flags the
// cycle on which each rising/falling MDC edge is registered.
module peg_l2_mdio_clk_gen #(
  parameter int MDC_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic mdc,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int              DIV_W    = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MDC_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_cntr_q, div_cntr_d;
  logic             mdc_q, mdc_d;
  logic             toggle;

  assign toggle = run && (div_cntr_q == DIV_LAST);

  always_comb begin
    div_cntr_d = '0;
    mdc_d      = 1'b0;
    if (run) begin
      div_cntr_d = toggle ? '0 : (div_cntr_q + DIV_ONE);
      mdc_d      = mdc_q ^ toggle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cntr_q <= '0;
      mdc_q      <= 1'b0;
    end else begin
      div_cntr_q <= div_cntr_d;
      mdc_q      <= mdc_d;
    end
  end

  assign mdc      = mdc_q;
  assign rise_stb = toggle & ~mdc_q;
  assign fall_stb = toggle &  mdc_q;

endmodule

// File: rtl/peg_l2_rs_rmii_link_ctrl.sv
// Polls PHY BMSR and a vendor speed register over clause-22 MDIO and drives the RMII RS
// speed select. Define PEG_L2_RMII_LINK_IRQ_EN to add the link_chg_irq output.
module peg_l2_rs_rmii_link_ctrl
  import peg_l2_mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR        = 5'd1,
  parameter int         MDC_DIV         = 10,
  parameter int         POLL_INTERVAL_W = 20,
  parameter logic [4:0] SPEED_REG       = 5'd31,
  parameter int         SPEED_BIT_POS   = 3
) (
  input  logic rmii_ref_clk,
  input  logic rst_n,
  input  logic ctrl_en,
  output logic mdc,
  output logic mdio_o,
  output logic mdio_oe,
  input  logic mdio_i,
  output logic config_rs_mii_speed_100_n_10,
  output logic link_up,
  output logic status_valid,
  output logic phy_err
`ifdef PEG_L2_RMII_LINK_IRQ_EN
  ,
  output logic link_chg_irq
`endif
);

  localparam logic [5:0] PRE_LAST  = 6'(MDIO_PREAMBLE_LEN - 1);
  localparam logic [5:0] HDR_LAST  = 6'(MDIO_HDR_LEN - 1);
  localparam logic [5:0] DATA_BITS = 6'(MDIO_DATA_LEN);
  localparam logic [5:0] TA_SAMPLE = 6'd1;
  localparam logic [POLL_INTERVAL_W-1:0] POLL_ONE = POLL_INTERVAL_W'(1);

  mdio_state_e           state_q, state_d;
  mdio_reg_sel_e         reg_sel_q, reg_sel_d;
  logic [5:0]            bit_cntr_q, bit_cntr_d;
  logic [POLL_INTERVAL_W-1:0] poll_cntr_q, poll_cntr_d;
  logic [13:0]           hdr_sr_q, hdr_sr_d;
  logic [15:0]           data_sr_q, data_sr_d;
  logic                  ta_fail_q, ta_fail_d;
  logic                  link_bit_q, link_bit_d;
  logic                  mdio_o_q, mdio_o_d;
  logic                  mdio_oe_q, mdio_oe_d;
  logic                  speed_q, speed_d;
  logic                  link_up_q, link_up_d;
  logic                  status_valid_q, status_valid_d;
  logic                  phy_err_q, phy_err_d;
  logic                  start_frame;
  logic                  run, rise_stb, fall_stb;
  logic [13:0]           hdr_word;

  assign run = (state_q == PREAMBLE_S) || (state_q == HDR_S) ||
               (state_q == TA_S) || (state_q == DATA_S);
  assign hdr_word = mdio_rd_hdr(PHY_ADDR, (reg_sel_q == SEL_BMSR) ? BMSR_ADDR : SPEED_REG);

  peg_l2_mdio_clk_gen #(
    .MDC_DIV (MDC_DIV)
  ) u_clk_gen (
    .clk      (rmii_ref_clk),
    .rst_n    (rst_n),
    .run      (run),
    .mdc      (mdc),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    state_d        = state_q;
    reg_sel_d      = reg_sel_q;
    bit_cntr_d     = bit_cntr_q;
    poll_cntr_d    = '0;
    hdr_sr_d       = hdr_sr_q;
    data_sr_d      = data_sr_q;
    ta_fail_d      = ta_fail_q;
    link_bit_d     = link_bit_q;
    mdio_o_d       = mdio_o_q;
    mdio_oe_d      = mdio_oe_q;
    speed_d        = speed_q;
    link_up_d      = link_up_q;
    status_valid_d = 1'b0;
    phy_err_d      = phy_err_q;
    start_frame    = 1'b0;

    case (state_q)
      IDLE_S: begin
        if (ctrl_en) begin
          reg_sel_d   = SEL_BMSR;
          start_frame = 1'b1;
        end
      end
      PREAMBLE_S: begin
        if (fall_stb) begin
          if (bit_cntr_q == PRE_LAST) begin
            state_d  = HDR_S;
            mdio_o_d = hdr_word[13];
            hdr_sr_d = {hdr_word[12:0], 1'b0};
          end else begin
            bit_cntr_d = bit_cntr_q + 6'd1;
          end
        end
      end
      HDR_S: begin
        if (fall_stb) begin
          if (bit_cntr_q == HDR_LAST) begin
            state_d   = TA_S;
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b1;
          end else begin
            mdio_o_d   = hdr_sr_q[13];
            hdr_sr_d   = {hdr_sr_q[12:0], 1'b0};
            bit_cntr_d = bit_cntr_q + 6'd1;
          end
        end
      end
      TA_S: begin
        // A failed TA still waits for the closing MDC fall so MDC never ends on a runt high.
        if (rise_stb) begin
          bit_cntr_d = bit_cntr_q + 6'd1;
          if (bit_cntr_q == TA_SAMPLE) begin
            if (!mdio_i) state_d = DATA_S;
            else         ta_fail_d = 1'b1;
          end
        end else if (fall_stb && ta_fail_q) begin
          state_d = DONE_S;
        end
      end
      DATA_S: begin
        if (rise_stb) begin
          data_sr_d  = {data_sr_q[14:0], mdio_i};
          bit_cntr_d = bit_cntr_q + 6'd1;
        end else if (fall_stb && (bit_cntr_q == DATA_BITS)) begin
          state_d = DONE_S;
        end
      end
      DONE_S: begin
        mdio_oe_d = 1'b0;
        mdio_o_d  = 1'b1;
        if (ta_fail_q) begin
          phy_err_d      = 1'b1;
          link_up_d      = 1'b0;
          status_valid_d = 1'b1;
          state_d        = WAIT_POLL_S;
        end else if (reg_sel_q == SEL_BMSR) begin
          link_bit_d  = data_sr_q[BMSR_LINK_BIT];
          reg_sel_d   = SEL_SPEED;
          start_frame = 1'b1;
        end else begin
          link_up_d = link_bit_q;
          phy_err_d = 1'b0;
          if (link_bit_q) speed_d = data_sr_q[SPEED_BIT_POS];
          status_valid_d = 1'b1;
          state_d        = WAIT_POLL_S;
        end
      end
      WAIT_POLL_S: begin
        poll_cntr_d = poll_cntr_q + POLL_ONE;
        if (!ctrl_en) begin
          state_d = IDLE_S;
        end else if (poll_cntr_q == '1) begin
          reg_sel_d   = SEL_BMSR;
          start_frame = 1'b1;
        end
      end
      default: state_d = IDLE_S;
    endcase

    // The first preamble bit goes out on entry, ahead of any MDC edge.
    if (start_frame) begin
      state_d   = PREAMBLE_S;
      mdio_o_d  = 1'b1;
      mdio_oe_d = 1'b1;
      ta_fail_d = 1'b0;
    end

    if (state_d != state_q) begin
      bit_cntr_d  = '0;
      poll_cntr_d = '0;
    end
  end

  always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE_S;
      reg_sel_q      <= SEL_BMSR;
      bit_cntr_q     <= '0;
      poll_cntr_q    <= '0;
      hdr_sr_q       <= '0;
      data_sr_q      <= '0;
      ta_fail_q      <= 1'b0;
      link_bit_q     <= 1'b0;
      mdio_o_q       <= 1'b1;
      mdio_oe_q      <= 1'b0;
      speed_q        <= 1'b1;
      link_up_q      <= 1'b0;
      status_valid_q <= 1'b0;
      phy_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      reg_sel_q      <= reg_sel_d;
      bit_cntr_q     <= bit_cntr_d;
      poll_cntr_q    <= poll_cntr_d;
      hdr_sr_q       <= hdr_sr_d;
      data_sr_q      <= data_sr_d;
      ta_fail_q      <= ta_fail_d;
      link_bit_q     <= link_bit_d;
      mdio_o_q       <= mdio_o_d;
      mdio_oe_q      <= mdio_oe_d;
      speed_q        <= speed_d;
      link_up_q      <= link_up_d;
      status_valid_q <= status_valid_d;
      phy_err_q      <= phy_err_d;
    end
  end

`ifdef PEG_L2_RMII_LINK_IRQ_EN
  logic link_chg_q, link_chg_d;

  assign link_chg_d = status_valid_d && ((link_up_d != link_up_q) || (speed_d != speed_q));

  always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
    if (!rst_n) link_chg_q <= 1'b0;
    else        link_chg_q <= link_chg_d;
  end

  assign link_chg_irq = link_chg_q;
`endif

  assign mdio_o                       = mdio_o_q;
  assign mdio_oe                      = mdio_oe_q;
  assign config_rs_mii_speed_100_n_10 = speed_q;
  assign link_up                      = link_up_q;
  assign status_valid                 = status_valid_q;
  assign phy_err                      = phy_err_q;

endmodule
